register_file_mp: RTL



---
 rtl/regfile_pkg.sv | 14 +
 rtl/register_file_mp_if.sv | 30 +++
 rtl/regfile_clear_fsm.sv | 65 ++++++
 rtl/register_file_mp.sv | 91 +++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its clear sequencer.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

  // Address width for a register count; never narrower than one bit.
  function automatic int addr_width(input int n_loc);
    return (n_loc > 1) ? $clog2(n_loc) : 1;
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Write/read/clear bus of the multi-port register file; the datapath is master, the file is slave.
interface register_file_mp_if
  import regfile_pkg::*;
#(
  parameter int Nloc  = 32,
  parameter int Dbits = 32,
  parameter int NRead = 2
);
  localparam int Abits = addr_width(Nloc);

  logic                   wr;
  logic [Abits-1:0]       WriteAddr;
  logic [Dbits-1:0]       WriteData;
  logic [NRead*Abits-1:0] ReadAddr;
  logic [NRead*Dbits-1:0] ReadData;
  logic                   clear_req;
  logic                   busy;
  logic                   wr_drop;

  modport master (
    output wr, WriteAddr, WriteData, ReadAddr, clear_req,
    input  ReadData, busy, wr_drop
  );

  modport slave (
    input  wr, WriteAddr, WriteData, ReadAddr, clear_req,
    output ReadData, busy, wr_drop
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks every location writing zero after reset or on clear_req,
// and flags user writes that arrive while the walk is running.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int Nloc  = 32,
  parameter int Abits = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_req,
  input  logic             wr,
  output logic             busy,
  output logic             wr_drop,
  output logic             clr_we,
  output logic [Abits-1:0] clr_addr
);

  localparam logic [Abits-1:0] LastAddr = Abits'(Nloc - 1);

  rf_state_t        r_state;
  logic [Abits-1:0] r_clr_addr;
  logic             r_wr_drop;
  logic             w_busy;

  assign w_busy   = (r_state == CLEAR);
  assign busy     = w_busy;
  assign clr_we   = w_busy;
  assign clr_addr = r_clr_addr;
  assign wr_drop  = r_wr_drop;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
      r_wr_drop  <= 1'b0;
    end else begin
      r_wr_drop <= wr & w_busy;
      case (r_state)
        CLEAR: begin
          if (r_clr_addr == LastAddr) begin
            r_state    <= IDLE;
            r_clr_addr <= '0;
          end else begin
            r_clr_addr <= r_clr_addr + Abits'(1);
          end
        end
        IDLE: begin
          // A request during CLEAR never reaches here, so a running walk is not restarted.
          if (clear_req) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
          end
        end
        default: begin
          r_state    <= CLEAR;
          r_clr_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised register file: NRead combinational read ports, one write port,
// optional hardwired-zero register 0, optional write-to-read bypass, built-in clear.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int Nloc    = 32,
  parameter int Dbits   = 32,
  parameter int NRead   = 2,
  parameter int ZeroReg = 1,
  parameter int Bypass  = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  register_file_mp_if.slave bus
);

  localparam int             Abits = addr_width(Nloc);
  localparam logic [Abits:0] NlocW = (Abits + 1)'(Nloc);

  logic [Dbits-1:0]                 r_mem [Nloc];
  logic                             w_busy;
  logic                             w_clr_we;
  logic [Abits-1:0]                 w_clr_addr;
  logic                             w_wr_addr_ok;
  logic                             w_wr_zero;
  logic                             w_user_we;
  logic                             w_we;
  logic [Abits-1:0]                 w_waddr;
  logic [Dbits-1:0]                 w_wdata;
  logic [NRead-1:0][Dbits-1:0]      w_read_data;

  regfile_clear_fsm #(
    .Nloc  (Nloc),
    .Abits (Abits)
  ) u_clear_fsm (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear_req (bus.clear_req),
    .wr        (bus.wr),
    .busy      (w_busy),
    .wr_drop   (bus.wr_drop),
    .clr_we    (w_clr_we),
    .clr_addr  (w_clr_addr)
  );

  assign bus.busy = w_busy;

  assign w_wr_addr_ok = ({1'b0, bus.WriteAddr} < NlocW);
  assign w_wr_zero    = (ZeroReg != 0) && (bus.WriteAddr == '0);
  assign w_user_we    = bus.wr & ~w_busy & w_wr_addr_ok & ~w_wr_zero;

  // Clear write wins over the user write; in practice busy already masks the latter.
  assign w_we    = w_clr_we | w_user_we;
  assign w_waddr = w_clr_we ? w_clr_addr : bus.WriteAddr;
  assign w_wdata = w_clr_we ? '0 : bus.WriteData;

  // NOTE: the array has no reset; the clear sequencer zeroes it, which keeps it
  // mappable onto plain RAM/flop arrays without a reset fan-out.
  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  for (genvar k = 0; k < NRead; k++) begin : g_read
    logic [Abits-1:0] w_raddr;
    logic             w_in_range;
    logic             w_zero;
    logic             w_hit;
    logic [Dbits-1:0] w_rdata;

    assign w_raddr    = bus.ReadAddr[k*Abits +: Abits];
    assign w_in_range = ({1'b0, w_raddr} < NlocW);
    assign w_zero     = (ZeroReg != 0) && (w_raddr == '0);
    assign w_hit      = (Bypass != 0) && bus.wr && (bus.WriteAddr == w_raddr);

    // NOTE: the default assignment first makes every path assign w_rdata,
    // so no latch is inferred.
    always_comb begin
      w_rdata = '0;
      if (!w_busy && w_in_range && !w_zero) begin
        w_rdata = w_hit ? bus.WriteData : r_mem[w_raddr];
      end
    end

    assign w_read_data[k] = w_rdata;
  end

  assign bus.ReadData = w_read_data;

endmodule
